pipeline_ctrl: RTL

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It combines the load-use stall from hazard detection, EX-stage branch redirects, slow data-memory/MMIO accesses and ECALL I/O waits. It drives per-register enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also keeps a saturating stall-cycle counter and latches a fault on a memory timeout.

---
 rtl/pipeline_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges load-use, branch, slow-MEM and ECALL waits into per-register enables/flushes.
// Latency: enables/flushes are combinational from state + inputs; state, timer and counters update on the next edge.
// Backpressure: a MEM wait freezes PC..EX/MEM, an ECALL wait freezes PC..ID/EX; a memory timeout freezes everything until rst.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_stall,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             ecall_ex,
    input  logic             io_confirm,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             ecall_busy,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int TMR_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        ECALL_WAIT = 2'd2,
        FAULT_ST   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        unique case (state)
            RUN: begin
                if (mem_req) begin
                    if (!mem_ready) begin
                        state_nxt = MEM_WAIT;
                        timer_nxt = TMR_W'(1);
                    end
                end else if (ecall_ex) begin
                    state_nxt = ECALL_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = RUN;
                    timer_nxt = '0;
                end else if (timer >= TMR_MAX) begin
                    state_nxt = FAULT_ST;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            ECALL_WAIT: begin
                if (io_confirm) state_nxt = RUN;
            end
            FAULT_ST: state_nxt = FAULT_ST;
            default:  state_nxt = RUN;
        endcase
    end

    // Enables are not masked by flushes; the datapath gives a flush precedence over its register's enable.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        ecall_busy   = 1'b0;
        fault        = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (mem_req) begin
                        if (!mem_ready) begin
                            pc_en        = 1'b0;
                            if_id_en     = 1'b0;
                            id_ex_en     = 1'b0;
                            ex_mem_en    = 1'b0;
                            mem_wb_flush = 1'b1;
                        end
                    end else if (ecall_ex) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end else if (br_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ld_stall) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_en    = 1'b0;
                        mem_wb_flush = 1'b1;
                    end
                end
                ECALL_WAIT: begin
                    ecall_busy = 1'b1;
                    if (!io_confirm) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end
                end
                FAULT_ST: begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                    fault     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Frozen cycles after a fault are not counted so the count reflects real stall cost.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!pc_en && state != FAULT_ST && stall_cycles != {CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
